// File: rtl/am_envelope_detector_if.sv
// Sample-in / envelope-out bundle for the AM envelope detector.
// The source side (modulator or bench) takes master; the detector takes slave.
interface am_envelope_detector_if #(
  parameter int unsigned DECIM_W = 8
);
  localparam int unsigned ENV_W = 12 + DECIM_W;

  logic                     i_enable;
  logic signed [11:0]       i_am_i;
  logic signed [11:0]       i_am_q;
  logic [DECIM_W-1:0]       i_decim;
  logic [ENV_W-1:0]         o_envelope;
  logic signed [ENV_W:0]    o_ac;
  logic                     o_valid;

  modport master (
    output i_enable, i_am_i, i_am_q, i_decim,
    input  o_envelope, o_ac, o_valid
  );

  modport slave (
    input  i_enable, i_am_i, i_am_q, i_decim,
    output o_envelope, o_ac, o_valid
  );
endinterface

// File: rtl/am_envelope_detector.sv
// I/Q magnitude estimate, accumulate-and-dump over a programmable window,
// and a one-pole DC tracker that strips the carrier level from each window sum.
module am_envelope_detector #(
  parameter int unsigned DECIM_W  = 8,
  parameter int unsigned DC_SHIFT = 6
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  am_envelope_detector_if.slave   bus
);
  localparam int unsigned ENV_W  = 12 + DECIM_W;
  localparam int unsigned DCA_W  = ENV_W + DC_SHIFT;

  // |x| on 11 bits; the single unrepresentable value -2048 clips to 2047
  function automatic logic [10:0] abs_sat(input logic [11:0] x);
    logic [11:0] neg;
    neg = ~x + 12'd1;
    if (x == 12'h800)  return 11'h7FF;
    else if (x[11])    return neg[10:0];
    else               return x[10:0];
  endfunction

  logic [10:0]              a_q, b_q;
  logic                     v1_q, v2_q;
  logic [11:0]              mag_q;
  logic [ENV_W-1:0]         acc_q;
  logic [DECIM_W-1:0]       cnt_q, win_len_q;
  logic [DCA_W-1:0]         dc_acc_q;
  logic [ENV_W-1:0]         env_q;
  logic signed [ENV_W:0]    ac_q;
  logic                     valid_q;

  logic [10:0]              mx_c, mn_c;
  logic [11:0]              mag_c;
  logic [DECIM_W-1:0]       eff_len_c;
  logic [ENV_W-1:0]         sum_c;
  logic [ENV_W-1:0]         dc_c;
  logic signed [ENV_W:0]    ac_c;

  // Alpha-max-plus-beta-min: max*(15/16) + min*(15/32), all floors
  always_comb begin
    mx_c  = (a_q >= b_q) ? a_q : b_q;
    mn_c  = (a_q >= b_q) ? b_q : a_q;
    mag_c = 12'(mx_c) - 12'(mx_c >> 4) + 12'(mn_c >> 1) - 12'(mn_c >> 5);
  end

  // Window length comes straight from i_decim on the first sample of a window
  always_comb begin
    eff_len_c = (cnt_q == '0) ? bus.i_decim : win_len_q;
    sum_c     = acc_q + ENV_W'(mag_q);
    dc_c      = ENV_W'(dc_acc_q >> DC_SHIFT);
    ac_c      = $signed({1'b0, sum_c}) - $signed({1'b0, dc_c});
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      a_q       <= '0;
      b_q       <= '0;
      v1_q      <= 1'b0;
      v2_q      <= 1'b0;
      mag_q     <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      win_len_q <= '0;
      dc_acc_q  <= '0;
      env_q     <= '0;
      ac_q      <= '0;
      valid_q   <= 1'b0;
    end else begin
      a_q     <= abs_sat(bus.i_am_i);
      b_q     <= abs_sat(bus.i_am_q);
      v1_q    <= bus.i_enable;
      mag_q   <= mag_c;
      v2_q    <= v1_q;
      valid_q <= 1'b0;
      if (v2_q) begin
        if (cnt_q == '0) win_len_q <= bus.i_decim;
        if (cnt_q < eff_len_c) begin
          acc_q <= sum_c;
          cnt_q <= cnt_q + DECIM_W'(1);
        end else begin
          // Dump: publish the window sum and advance the DC tracker
          env_q    <= sum_c;
          ac_q     <= ac_c;
          valid_q  <= 1'b1;
          dc_acc_q <= dc_acc_q + DCA_W'(sum_c) - DCA_W'(dc_c);
          acc_q    <= '0;
          cnt_q    <= '0;
        end
      end
    end
  end

  assign bus.o_envelope = env_q;
  assign bus.o_ac       = ac_q;
  assign bus.o_valid    = valid_q;
endmodule

// File: tb/tb_am_envelope_detector.sv
// Scoreboard bench for am_envelope_detector: a behavioural model queues each
// expected dump (sum, AC value, arrival cycle) and a monitor retires them.
module tb_am_envelope_detector;
  localparam int unsigned DECIM_W  = 8;
  localparam int unsigned DC_SHIFT = 6;

  typedef struct {
    longint env;
    longint ac;
    longint cyc;
  } exp_t;

  logic   clk = 1'b0;
  logic   rst = 1'b1;
  longint cyc = 0;
  int     checks = 0;
  int     errors = 0;
  exp_t   sb[$];

  longint m_acc = 0, m_cnt = 0, m_win = 0, m_dc_acc = 0;
  int     cur_decim = 3;

  am_envelope_detector_if #(.DECIM_W(DECIM_W)) bus ();

  am_envelope_detector #(.DECIM_W(DECIM_W), .DC_SHIFT(DC_SHIFT)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic longint mag_model(input int i, input int q);
    longint a, b, mx, mn;
    a = (i < 0) ? -i : i;
    b = (q < 0) ? -q : q;
    if (a > 2047) a = 2047;
    if (b > 2047) b = 2047;
    mx = (a > b) ? a : b;
    mn = (a > b) ? b : a;
    return mx - mx / 16 + mn / 2 - mn / 32;
  endfunction

  // Drive one cycle of input and advance the reference model for accepted samples
  task automatic drive(input bit en, input int i, input int q);
    longint m, x, dc;
    exp_t   e;
    @(negedge clk);
    bus.i_enable = en;
    bus.i_am_i   = 12'(i);
    bus.i_am_q   = 12'(q);
    bus.i_decim  = 8'(cur_decim);
    if (en) begin
      m = mag_model(i, q);
      if (m_cnt == 0) m_win = cur_decim;
      if (m_cnt < m_win) begin
        m_acc += m;
        m_cnt++;
      end else begin
        x        = m_acc + m;
        dc       = m_dc_acc / (longint'(1) << DC_SHIFT);
        e.env    = x;
        e.ac     = x - dc;
        e.cyc    = cyc + 3;
        sb.push_back(e);
        m_dc_acc = m_dc_acc + x - dc;
        m_acc    = 0;
        m_cnt    = 0;
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 0, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst          = 1'b1;
    bus.i_enable = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_env", bus.o_envelope, 0);
    check("rst_ac", bus.o_ac, 0);
    check("rst_valid", bus.o_valid, 0);
    check("rst_pending", sb.size(), 0);
    sb.delete();
    rst      = 1'b0;
    m_acc    = 0;
    m_cnt    = 0;
    m_dc_acc = 0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("drain", sb.size(), 0);
  endtask

  // Retire one expectation per o_valid pulse; a pulse with nothing queued is an error
  always @(negedge clk) begin
    exp_t e;
    if (bus.o_valid === 1'b1) begin
      if (sb.size() == 0) begin
        check("spurious_valid", 1, 0);
      end else begin
        e = sb.pop_front();
        check("envelope", bus.o_envelope, e.env);
        check("ac", bus.o_ac, e.ac);
        check("latency", cyc, e.cyc);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1);
  end

  initial begin
    bus.i_enable = 1'b0;
    bus.i_am_i   = '0;
    bus.i_am_q   = '0;
    bus.i_decim  = 8'(cur_decim);
    do_reset();

    // Constant carrier, 4-sample windows; exercises DC convergence
    cur_decim = 3;
    repeat (40) drive(1'b1, 1000, 0);
    idle(4);

    // Magnitude corners, one sample per window
    cur_decim = 0;
    idle(3);
    drive(1'b1, -2048, 0);
    drive(1'b1, 1000, 1000);
    drive(1'b1, 0, -5);
    drive(1'b1, 0, 0);
    drive(1'b1, -2048, -2048);
    idle(4);

    // Enable gap of 5 cycles inside a window
    cur_decim = 3;
    idle(3);
    drive(1'b1, 300, -200);
    drive(1'b1, -700, 50);
    idle(5);
    drive(1'b1, 1500, 1500);
    drive(1'b1, -2048, 2047);
    idle(4);

    // Window length 3 -> 7 mid-window only affects the following window
    drive(1'b1, 100, 0);
    drive(1'b1, 200, -10);
    drive(1'b1, -300, 20);
    cur_decim = 7;
    for (int j = 1; j <= 9; j++) drive(1'b1, 100 * j, -50 * j);
    idle(4);
    drain();

    // Reset after a partial window: fresh sums and DC restart
    idle(2);
    cur_decim = 3;
    idle(3);
    drive(1'b1, 1200, 400);
    drive(1'b1, 1200, 400);
    do_reset();
    drive(1'b1, 500, 0);
    drive(1'b1, 600, -100);
    drive(1'b1, -700, 200);
    drive(1'b1, 800, 800);
    idle(4);
    drain();

    // Random samples, gappy enable, a few window lengths
    for (int blk = 0; blk < 3; blk++) begin
      idle(4);
      cur_decim = int'($urandom_range(0, 5));
      repeat (30)
        drive($urandom_range(0, 3) != 0,
              int'($urandom_range(0, 4095)) - 2048,
              int'($urandom_range(0, 4095)) - 2048);
    end
    idle(10);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
